// File: rtl/parity_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_rx
// Description : Serial receiver for start/data/parity/stop frames; deserialises
//               the word and reports parity and framing status.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_rx #(
    parameter int DATA_W     = 3,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int                 c_cnt_w   = $clog2(DATA_W + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DATA_W - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DATA    = 3'd1,
        S_PARITY  = 3'd2,
        S_STOP    = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    state_t              r_state;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_acc;
    logic                r_perr;
    logic [DATA_W-1:0]   w_shift_next;

    // Bits enter at the MSB and walk down, so after DATA_W shifts the first
    // received bit sits at index 0 (LSB-first ordering).
    generate
        if (DATA_W == 1) begin : g_shift_one
            assign w_shift_next = rx_in;
        end else begin : g_shift_multi
            assign w_shift_next = {rx_in, r_shift[DATA_W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_shift    <= '0;
            r_acc      <= 1'b0;
            r_perr     <= 1'b0;
            data_out   <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (bit_en) begin
                case (r_state)
                    S_IDLE: begin
                        if (!rx_in) begin
                            r_state <= S_DATA;
                            r_cnt   <= '0;
                            r_acc   <= 1'b0;
                            busy    <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_shift <= w_shift_next;
                        r_acc   <= r_acc ^ rx_in;
                        r_cnt   <= r_cnt + c_cnt_one;
                        if (r_cnt == c_cnt_last) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_perr  <= r_acc ^ rx_in ^ ODD_PARITY;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        if (rx_in) begin
                            data_out   <= r_shift;
                            parity_err <= r_perr;
                            valid      <= 1'b1;
                            busy       <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            // Break or bad stop: hold until the line returns high
                            frame_err <= 1'b1;
                            r_state   <= S_RECOVER;
                        end
                    end
                    S_RECOVER: begin
                        if (rx_in) begin
                            busy    <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_frame_rx
// Description : Directed bench for parity_frame_rx (even and odd builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_en = 1'b0;
    logic       rx_in = 1'b1;
    logic [2:0] data_e, data_o;
    logic       valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

    int checks = 0;
    int errors = 0;
    int nstrobes = 0;

    always #5 clk = ~clk;

    parity_frame_rx #(.DATA_W(3), .ODD_PARITY(1'b0)) u_even (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_in(rx_in),
        .data_out(data_e), .valid(valid_e), .parity_err(perr_e),
        .frame_err(ferr_e), .busy(busy_e)
    );

    parity_frame_rx #(.DATA_W(3), .ODD_PARITY(1'b1)) u_odd (
        .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .rx_in(rx_in),
        .data_out(data_o), .valid(valid_o), .parity_err(perr_o),
        .frame_err(ferr_o), .busy(busy_o)
    );

    typedef struct {
        logic [2:0] d;
        logic       p;
        logic       s;
        int         gap;
        logic       ev;
        logic [2:0] ed;
        logic       epe;
        logic       epo;
        logic       ef;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Idle cycles toggle rx_in so that non-strobe glitches are exercised.
    task automatic strobe(input logic b, input int gap);
        for (int i = 0; i < gap; i++) begin
            bit_en = 1'b0;
            rx_in  = ~rx_in;
            @(posedge clk);
            #1;
        end
        bit_en = 1'b1;
        rx_in  = b;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        nstrobes++;
    endtask

    task automatic send_frame(input logic [2:0] d, input logic p, input logic s, input int gap);
        strobe(1'b0, gap);
        chk("start_busy", 32'(busy_e), 32'd1);
        chk("start_valid", 32'(valid_e), 32'd0);
        for (int i = 0; i < 3; i++) strobe(d[i], gap);
        strobe(p, gap);
        strobe(s, gap);
    endtask

    initial begin
        tbl[0]  = '{3'd5, 1'b0, 1'b1, 0, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{3'd5, 1'b1, 1'b1, 0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{3'd0, 1'b0, 1'b1, 3, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0};
        tbl[3]  = '{3'd1, 1'b1, 1'b1, 3, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{3'd2, 1'b1, 1'b1, 3, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{3'd3, 1'b0, 1'b1, 3, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{3'd4, 1'b1, 1'b1, 3, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{3'd5, 1'b0, 1'b1, 3, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{3'd6, 1'b0, 1'b1, 3, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{3'd7, 1'b1, 1'b1, 3, 1'b1, 3'd7, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{3'd3, 1'b0, 1'b0, 0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", 32'(data_e), 32'd0);
        chk("rst_valid", 32'(valid_e), 32'd0);
        chk("rst_perr", 32'(perr_e), 32'd0);
        chk("rst_ferr", 32'(ferr_e), 32'd0);
        chk("rst_busy", 32'(busy_e), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 11; k++) begin
            send_frame(tbl[k].d, tbl[k].p, tbl[k].s, tbl[k].gap);
            chk($sformatf("v%0d_valid", k), 32'(valid_e), 32'(tbl[k].ev));
            chk($sformatf("v%0d_ferr", k), 32'(ferr_e), 32'(tbl[k].ef));
            chk($sformatf("v%0d_data", k), 32'(data_e), 32'(tbl[k].ed));
            chk($sformatf("v%0d_perr_even", k), 32'(perr_e), 32'(tbl[k].epe));
            chk($sformatf("v%0d_perr_odd", k), 32'(perr_o), 32'(tbl[k].epo));
            chk($sformatf("v%0d_busy", k), 32'(busy_e), 32'(tbl[k].ef));
        end

        // Frame error recovery: line must return high before a new start counts
        @(posedge clk);
        #1;
        chk("ferr_pulse_end", 32'(ferr_e), 32'd0);
        chk("recover_busy", 32'(busy_e), 32'd1);
        strobe(1'b0, 0);
        chk("recover_low_busy", 32'(busy_e), 32'd1);
        chk("recover_low_valid", 32'(valid_e), 32'd0);
        strobe(1'b1, 0);
        chk("recover_exit_busy", 32'(busy_e), 32'd0);
        chk("recover_exit_data", 32'(data_e), 32'd7);

        // Asynchronous reset mid-frame
        strobe(1'b0, 0);
        strobe(1'b1, 0);
        strobe(1'b1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", 32'(data_e), 32'd0);
        chk("async_rst_busy", 32'(busy_e), 32'd0);
        chk("async_rst_perr_odd", 32'(perr_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_frame(3'd3, 1'b0, 1'b1, 1);
        chk("post_rst_valid", 32'(valid_e), 32'd1);
        chk("post_rst_data", 32'(data_e), 32'd3);
        chk("post_rst_perr_odd", 32'(perr_o), 32'd1);

        // Back-to-back frames with no idle strobe
        begin
            int s1;
            send_frame(3'd6, 1'b0, 1'b1, 0);
            chk("b2b1_valid", 32'(valid_e), 32'd1);
            chk("b2b1_data", 32'(data_e), 32'd6);
            s1 = nstrobes;
            send_frame(3'd1, 1'b1, 1'b1, 0);
            chk("b2b2_valid", 32'(valid_e), 32'd1);
            chk("b2b2_data", 32'(data_e), 32'd1);
            chk("b2b2_perr", 32'(perr_e), 32'd0);
            chk("b2b_spacing", 32'(nstrobes - s1), 32'd6);
        end
        @(posedge clk);
        #1;
        chk("final_valid_low", 32'(valid_e), 32'd0);
        chk("final_busy", 32'(busy_e), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/parity_frame_rx.md
# parity_frame_rx

Serial receiver and checker for parity-protected frames: one start bit, DATA_W data bits LSB first, one parity bit, one stop bit. It deserialises the frame and recomputes parity as the XOR of the received data bits. It then presents the word together with parity and framing status. It is the receiving end of the XOR parity generator used in the lab datapath, and it sits between the serial link and downstream consumer logic.

## Interface
- DATA_W, 3, number of data bits per frame (1..16)
- ODD_PARITY, 0, 0 = even parity (XOR of data and parity bit must be 0); 1 = odd parity (XOR must be 1)

- clk  input  1  single system clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- bit_en  input  1  bit-sample strobe; rx_in is sampled only on clk edges where bit_en=1
- rx_in  input  1  serial line, idle high
- data_out  output  DATA_W  last received word; held until the next valid
- valid  output  1  one-cycle pulse: a frame with a good stop bit completed
- parity_err  output  1  parity status of the word in data_out; meaningful from a valid pulse until the next one
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- busy  output  1  high in every state except IDLE

## Operation
- Reset values: data_out=0, valid=0, parity_err=0, frame_err=0, busy=0, FSM=IDLE, bit counter=0, parity accumulator=0.
- On cycles with bit_en=0, the FSM, shift register and accumulator hold. valid and frame_err still return to 0.
- FSM states:
  - IDLE: on a strobe with rx_in=0, go to DATA and clear the counter and accumulator. On a strobe with rx_in=1, stay in IDLE.
  - DATA: on each strobe, shift rx_in in at bit index = counter (LSB first), XOR it into the accumulator, and increment the counter. After DATA_W strobes, go to PARITY.
  - PARITY: on a strobe, compute err = accumulator ^ rx_in ^ ODD_PARITY, latch err internally, and go to STOP.
  - STOP:
    - On a strobe with rx_in=1: load data_out from the shift register, load parity_err from the latched err, pulse valid, and go to IDLE.
    - On a strobe with rx_in=0: pulse frame_err, leave data_out and parity_err unchanged, and go to RECOVER.
  - RECOVER: wait for a strobe with rx_in=1, then go to IDLE. A break condition therefore never starts a false frame.
- valid and frame_err are never high in the same cycle.
- A frame with a parity error still produces valid=1; the consumer decides what to do with it.
- Counter width is clog2(DATA_W+1). The counter never wraps, because the state changes when the count reaches DATA_W.
- Reset asserted mid-frame: all state and outputs return to reset values immediately, without waiting for a clock edge. The partial frame is discarded. After release, the block waits in IDLE for a new start bit.

## Timing
- All outputs are registered.
- valid or frame_err goes high in the cycle after the clk edge on which the stop-bit strobe was sampled, and stays high for exactly one cycle.
- data_out and parity_err update on that same edge.
- Minimum frame length is DATA_W+3 strobes. Strobes may be back-to-back (bit_en held at 1) or separated by any number of idle cycles.
- Back-to-back frames: the start bit of the next frame may be sampled on the strobe immediately after the stop bit. The valid pulse and the transition to DATA can occur in the same cycle.
- busy rises in the cycle after the start-bit strobe and falls in the cycle after the stop-bit strobe, or after the RECOVER exit strobe.

## Test plan
- Even parity, DATA_W=3, bit_en held at 1, rx_in sequence 0,1,0,1,0,1 -> valid pulse with data_out=3'b101, parity_err=0, busy=0 afterwards.
- Same frame with parity bit 1 -> valid=1, data_out=3'b101, parity_err=1. Then an ODD_PARITY=1 build sending parity bit 1 -> parity_err=0.
- Stop bit 0 (sequence 0,1,1,0,0,0) -> frame_err pulse, no valid, data_out keeps its previous value, busy stays high until a strobe with rx_in=1 is seen.
- bit_en pulsed every 4th cycle, with rx_in toggling on non-strobe cycles -> the glitches are ignored, and all 8 data values 0..7 are received with the correct parity_err.
- Reset pulse after the second data bit, then a clean frame carrying 3'b011 -> outputs go to 0 immediately on reset, and the next valid carries data_out=3'b011.
- Two frames back-to-back with no idle strobe between them (3'b110, then 3'b001) -> two valid pulses exactly DATA_W+3 strobes apart, each with the correct data.
